// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and
// the handshake level constants used on start_i and ready_o.
package div_seq_pkg;

    typedef enum logic [2:0] {
        ST_FREE   = 3'b000,
        ST_BYZERO = 3'b001,
        ST_ON     = 3'b010,
        ST_FIXUP  = 3'b011,
        ST_END    = 3'b100
    } div_state_t;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and try to subtract the divisor. The top bit of the WIDTH+1-bit
// difference is the borrow; a borrow means restore (q=0), else keep the
// difference (q=1). Since the incoming remainder is always below the divisor,
// the kept value always fits in WIDTH bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    // Trial subtract and restore selection
    always_comb begin
        partial  = {rem, dvd_bit};
        diff     = partial - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider (signed or unsigned). An operation is
// accepted in FREE, iterates WIDTH steps in ON, applies the sign correction
// in FIXUP and presents {remainder, quotient} in END until start_i drops.
// Divide-by-zero short-cuts through BYZERO and reports dbz_o with a zero
// result.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 dbz_o
);

    localparam int                 CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic              dbz_q;

    // Latched operation context (data path, no reset needed)
    logic              signed_q;
    logic              dvd_sign_q;
    logic              dvs_sign_q;
    logic [WIDTH-1:0]  divisor_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;

    // Control decodes
    logic              load_en;
    logic              step_en;
    logic              fix_en;
    logic              end_hold;
    logic              last_step;

    // Input conditioning
    logic              signed_in;
    logic signed [WIDTH-1:0] dvd_s;
    logic signed [WIDTH-1:0] dvs_s;
    logic [WIDTH-1:0]  dvd_abs;
    logic [WIDTH-1:0]  dvs_abs;

    // Step outputs
    logic [WIDTH-1:0]  rem_next;
    logic              q_bit;

    logic              neg_quo;
    logic              neg_rem;

    // Two's-complement negation; MIN maps to itself, which is exactly the
    // wrap required for MIN / -1 and gives |MIN| as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Magnitude of a signed operand when signed mode is active
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic               use_sign);
        return (use_sign && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    // Operand conditioning for the accept edge
    always_comb begin
        signed_in = (SIGNED_EN != 0) && signed_div_i;
        dvd_s     = opdata1_i;
        dvs_s     = opdata2_i;
        dvd_abs   = magnitude(dvd_s, signed_in);
        dvs_abs   = magnitude(dvs_s, signed_in);
        last_step = (cnt == LAST_STEP);
        neg_quo   = signed_q && (dvd_sign_q ^ dvs_sign_q);
        neg_rem   = signed_q && dvd_sign_q;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .dvd_bit  (quo_q[WIDTH-1]),
        .divisor  (divisor_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        step_en   = 1'b0;
        fix_en    = 1'b0;
        end_hold  = 1'b0;
        case (state)
            ST_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    load_en   = 1'b1;
                    state_nxt = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                state_nxt = ST_END;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_nxt = ST_FREE;
                end else begin
                    step_en = 1'b1;
                    if (last_step) begin
                        state_nxt = ST_FIXUP;
                    end
                end
            end
            ST_FIXUP: begin
                if (annul_i) begin
                    state_nxt = ST_FREE;
                end else begin
                    fix_en    = 1'b1;
                    state_nxt = ST_END;
                end
            end
            ST_END: begin
                if (start_i == DIV_STOP) begin
                    state_nxt = ST_FREE;
                end else begin
                    end_hold = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_FREE;
            end
        endcase
    end

    assign busy_o = (state != ST_FREE);

    // Iteration counter and divide-by-zero marker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            dbz_q <= 1'b0;
        end else begin
            cnt <= (step_en && !last_step) ? cnt + CNT_W'(1) : '0;
            if (load_en) begin
                dbz_q <= (opdata2_i == '0);
            end
        end
    end

    // Operand latch, shift-subtract iteration and sign fix-up
    always_ff @(posedge clk) begin
        if (load_en) begin
            signed_q   <= signed_in;
            dvd_sign_q <= opdata1_i[WIDTH-1];
            dvs_sign_q <= opdata2_i[WIDTH-1];
            divisor_q  <= dvs_abs;
            quo_q      <= dvd_abs;
            rem_q      <= '0;
        end else if (step_en) begin
            rem_q <= rem_next;
            quo_q <= {quo_q[WIDTH-2:0], q_bit};
        end else if (fix_en) begin
            if (neg_quo) begin
                quo_q <= negate(quo_q);
            end
            if (neg_rem) begin
                rem_q <= negate(rem_q);
            end
        end
    end

    // Registered result presentation; anything other than a held END is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            dbz_o    <= 1'b0;
        end else if (end_hold) begin
            result_o <= dbz_q ? '0 : {rem_q, quo_q};
            ready_o  <= DIV_RESULT_READY;
            dbz_o    <= dbz_q;
        end else begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            dbz_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a 32-bit instance and an 8-bit instance share
// clock and reset. Inputs change on the falling edge; outputs are sampled 1ns
// after the rising edge. The accept edge is counted as edge 1.
module tb_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        sd32, st32, an32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32, bsy32, dbz32;

    logic        sd8, st8, an8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, bsy8, dbz8;

    int errors = 0;
    int checks = 0;

    div_seq #(.WIDTH(32), .SIGNED_EN(1)) u_dut32 (
        .clk(clk), .rst(rst), .signed_div_i(sd32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32),
        .busy_o(bsy32), .dbz_o(dbz32)
    );

    div_seq #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
        .clk(clk), .rst(rst), .signed_div_i(sd8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8),
        .busy_o(bsy8), .dbz_o(dbz8)
    );

    // Present an operation; returns right after the accept edge (edge 1)
    task automatic launch32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sd32 = sgn; a32 = a; b32 = b; st32 = 1'b1;
        @(posedge clk);
    endtask

    // Release start_i; returns 1ns after the edge that sees it low
    task automatic drop32();
        @(negedge clk);
        st32 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy32); end
        checks++; if (bsy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bsy32); end
        checks++; if (dbz32 !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", dbz32); end
        checks++; if (res32 !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", res32); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (res32 !== 64'h0 || rdy32 !== 1'b0) begin errors++; $display("FAIL idle_free: got %h/%b expected 0/0", res32, rdy32); end
    endtask

    task automatic test_unsigned();
        launch32(1'b0, 32'd100, 32'd7);
        repeat (33) @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL u100_7_early: ready got %b expected 0 at edge 34", rdy32); end
        @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL u100_7_ready: got %b expected 1 at edge 35", rdy32); end
        checks++; if (res32 !== 64'h00000002_0000000E) begin errors++; $display("FAIL u100_7_result: got %h expected 000000020000000e", res32); end
        checks++; if (dbz32 !== 1'b0) begin errors++; $display("FAIL u100_7_dbz: got %b expected 0", dbz32); end
        drop32();
        checks++; if (rdy32 !== 1'b0 || res32 !== 64'h0 || bsy32 !== 1'b0) begin
            errors++; $display("FAIL u100_7_drop: ready %b result %h busy %b expected 0/0/0", rdy32, res32, bsy32);
        end
        // Signed-looking dividend in unsigned mode
        launch32(1'b0, 32'hFFFFFFF9, 32'd2);
        repeat (34) @(posedge clk); #1;
        checks++; if (res32 !== 64'h00000001_7FFFFFFC) begin errors++; $display("FAIL ubig_2_result: got %h expected 000000017ffffffc", res32); end
        drop32();
    endtask

    task automatic test_signed();
        launch32(1'b1, 32'hFFFFFFF9, 32'd2);
        repeat (34) @(posedge clk); #1;
        checks++; if (res32 !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL sneg7_2: got %h expected fffffffffffffffd", res32); end
        drop32();
        launch32(1'b1, 32'd7, 32'hFFFFFFFE);
        repeat (34) @(posedge clk); #1;
        checks++; if (res32 !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL s7_neg2: got %h expected 00000001fffffffd", res32); end
        drop32();
        launch32(1'b1, 32'h80000000, 32'hFFFFFFFF);
        repeat (34) @(posedge clk); #1;
        checks++; if (res32 !== 64'h00000000_80000000) begin errors++; $display("FAIL smin_neg1: got %h expected 0000000080000000", res32); end
        checks++; if (dbz32 !== 1'b0) begin errors++; $display("FAIL smin_neg1_dbz: got %b expected 0", dbz32); end
        drop32();
    endtask

    task automatic test_div_by_zero();
        launch32(1'b1, 32'd12345, 32'd0);
        @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL dbz_early: ready got %b expected 0 at edge 2", rdy32); end
        @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b1 || dbz32 !== 1'b1) begin errors++; $display("FAIL dbz_flag: ready %b dbz %b expected 1/1 at edge 3", rdy32, dbz32); end
        checks++; if (res32 !== 64'h0) begin errors++; $display("FAIL dbz_result: got %h expected 0", res32); end
        drop32();
        checks++; if (rdy32 !== 1'b0 || dbz32 !== 1'b0 || bsy32 !== 1'b0 || res32 !== 64'h0) begin
            errors++; $display("FAIL dbz_drop: ready %b dbz %b busy %b result %h expected all 0", rdy32, dbz32, bsy32, res32);
        end
    endtask

    task automatic test_annul();
        logic seen_ready;
        launch32(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        an32 = 1'b1; st32 = 1'b0;
        @(posedge clk); #1;
        checks++; if (bsy32 !== 1'b0) begin errors++; $display("FAIL annul_busy: got %b expected 0", bsy32); end
        @(negedge clk);
        an32 = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rdy32 === 1'b1) seen_ready = 1'b1;
        end
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL annul_no_ready: got %b expected 0", seen_ready); end
        launch32(1'b0, 32'd50, 32'd5);
        repeat (34) @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b1 || res32 !== 64'h00000000_0000000A) begin
            errors++; $display("FAIL after_annul: ready %b result %h expected 1/000000000000000a", rdy32, res32);
        end
        drop32();
    endtask

    task automatic test_reset_mid();
        launch32(1'b0, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0; st32 = 1'b0;
        #1;
        checks++; if (bsy32 !== 1'b0 || rdy32 !== 1'b0 || res32 !== 64'h0) begin
            errors++; $display("FAIL reset_mid: busy %b ready %b result %h expected 0/0/0", bsy32, rdy32, res32);
        end
        @(negedge clk);
        rst = 1'b1;
        launch32(1'b0, 32'd9, 32'd4);
        repeat (33) @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL post_reset_early: ready got %b expected 0", rdy32); end
        @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b1 || res32 !== 64'h00000001_00000002) begin
            errors++; $display("FAIL post_reset_op: ready %b result %h expected 1/0000000100000002", rdy32, res32);
        end
        drop32();
    endtask

    task automatic test_back_to_back();
        launch32(1'b0, 32'd20, 32'd6);
        repeat (34) @(posedge clk);
        repeat (3) @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b1 || bsy32 !== 1'b1 || res32 !== 64'h00000002_00000003) begin
            errors++; $display("FAIL end_hold: ready %b busy %b result %h expected 1/1/0000000200000003", rdy32, bsy32, res32);
        end
        drop32();
        launch32(1'b1, 32'd45, 32'd9);
        repeat (34) @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b1 || res32 !== 64'h00000000_00000005) begin
            errors++; $display("FAIL b2b_second: ready %b result %h expected 1/0000000000000005", rdy32, res32);
        end
        drop32();
    endtask

    task automatic test_width8();
        @(negedge clk);
        sd8 = 1'b0; a8 = 8'd200; b8 = 8'd3; st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd1; sd8 = 1'b1;
        repeat (9) @(posedge clk); #1;
        checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL w8_early: ready got %b expected 0 at edge 10", rdy8); end
        @(posedge clk); #1;
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL w8_ready: got %b expected 1 at edge 11", rdy8); end
        checks++; if (res8 !== 16'h0242) begin errors++; $display("FAIL w8_result: got %h expected 0242", res8); end
        @(negedge clk);
        st8 = 1'b0;
        @(posedge clk); #1;
        checks++; if (rdy8 !== 1'b0 || res8 !== 16'h0) begin errors++; $display("FAIL w8_drop: ready %b result %h expected 0/0000", rdy8, res8); end
    endtask

    initial begin
        rst = 1'b0;
        sd32 = 1'b0; st32 = 1'b0; an32 = 1'b0; a32 = '0; b32 = '0;
        sd8  = 1'b0; st8  = 1'b0; an8  = 1'b0; a8  = '0; b8  = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
